// File: rtl/uart_cmd_decoder_if.sv
// Byte-in / pulse-out bundle between the UART receiver, the command decoder and the game top.
interface uart_cmd_decoder_if #(
    parameter int unsigned FIFO_DEPTH = 4
) ();
    logic [7:0]                  rx_data;
    logic                        rx_valid;
    logic                        accept_en;
    logic                        clr_stats;
    logic                        move_left;
    logic                        move_right;
    logic                        move_made;
    logic                        reset_req;
    logic [7:0]                  last_cmd;
    logic [7:0]                  cmd_count;
    logic [3:0]                  err_count;
    logic                        overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    modport master (
        output rx_data, rx_valid, accept_en, clr_stats,
        input  move_left, move_right, move_made, reset_req,
        input  last_cmd, cmd_count, err_count, overflow, fifo_level
    );

    modport slave (
        input  rx_data, rx_valid, accept_en, clr_stats,
        output move_left, move_right, move_made, reset_req,
        output last_cmd, cmd_count, err_count, overflow, fifo_level
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// Turns UART command bytes into spaced one-cycle game control pulses via a small FIFO,
// and keeps command/error statistics for the seven-segment displays.
//
// state   | meaning
// IDLE    | waiting for a queued command while accept_en is high
// PULSE   | one move pulse is on the outputs this cycle
// GAP     | forced idle spacing, counting GAP_CYCLES down
module uart_cmd_decoder #(
    parameter int unsigned GAP_CYCLES = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  CMD_RIGHT  = 8'h01,
    parameter logic [7:0]  CMD_LEFT   = 8'h02,
    parameter logic [7:0]  CMD_DROP   = 8'h03,
    parameter logic [7:0]  CMD_RESET  = 8'h04
) (
    input logic               clk,
    input logic               rstn,
    uart_cmd_decoder_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned LW = PW + 1;

    localparam logic [1:0] OP_RIGHT = 2'd0;
    localparam logic [1:0] OP_LEFT  = 2'd1;
    localparam logic [1:0] OP_DROP  = 2'd2;

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    gap_cnt_q, gap_cnt_d;
    logic [1:0]    mem_q [FIFO_DEPTH];
    logic [1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          move_left_q, move_left_d;
    logic          move_right_q, move_right_d;
    logic          move_made_q, move_made_d;
    logic          reset_req_q, reset_req_d;
    logic [7:0]    last_cmd_q, last_cmd_d;
    logic [7:0]    cmd_count_q, cmd_count_d;
    logic [3:0]    err_count_q, err_count_d;
    logic          overflow_q, overflow_d;

    logic       is_move, is_reset, is_invalid;
    logic [1:0] rx_op;
    logic       empty, full, pop, push, drop;

    always_comb begin
        rx_op      = OP_RIGHT;
        is_move    = 1'b0;
        is_reset   = 1'b0;
        is_invalid = 1'b0;
        if (bus.rx_valid) begin
            if (bus.rx_data == CMD_RIGHT) begin
                is_move = 1'b1;
                rx_op   = OP_RIGHT;
            end else if (bus.rx_data == CMD_LEFT) begin
                is_move = 1'b1;
                rx_op   = OP_LEFT;
            end else if (bus.rx_data == CMD_DROP) begin
                is_move = 1'b1;
                rx_op   = OP_DROP;
            end else if (bus.rx_data == CMD_RESET) begin
                is_reset = 1'b1;
            end else begin
                is_invalid = 1'b1;
            end
        end
    end

    assign empty = (level_q == '0);
    assign full  = (level_q == LW'(FIFO_DEPTH));
    // A reset command flushes the queue, so nothing may be popped alongside it.
    assign pop   = (state_q == S_IDLE) && !empty && bus.accept_en && !is_reset;
    assign push  = is_move && (!full || pop);
    assign drop  = is_move && !push;

    always_comb begin
        state_d      = state_q;
        gap_cnt_d    = gap_cnt_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        move_left_d  = 1'b0;
        move_right_d = 1'b0;
        move_made_d  = 1'b0;
        reset_req_d  = is_reset;
        last_cmd_d   = last_cmd_q;
        cmd_count_d  = cmd_count_q;
        err_count_d  = err_count_q;
        overflow_d   = overflow_q;

        if (is_reset) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = rx_op;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + LW'(push) - LW'(pop);
        end

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_PULSE;
                    case (mem_q[rd_ptr_q])
                        OP_RIGHT: move_right_d = 1'b1;
                        OP_LEFT:  move_left_d  = 1'b1;
                        default:  move_made_d  = 1'b1;
                    endcase
                end
            end
            S_PULSE: begin
                gap_cnt_d = 8'(GAP_CYCLES);
                state_d   = S_GAP;
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - 1'b1;
                if (gap_cnt_q <= 8'd1) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push || is_reset) begin
            last_cmd_d = bus.rx_data;
        end

        if (bus.clr_stats) begin
            cmd_count_d = '0;
            err_count_d = '0;
            overflow_d  = 1'b0;
        end else begin
            if (push || is_reset) begin
                cmd_count_d = cmd_count_q + 8'd1;
            end
            if ((is_invalid || drop) && (err_count_q != 4'hF)) begin
                err_count_d = err_count_q + 4'd1;
            end
            if (drop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            gap_cnt_q    <= '0;
            mem_q        <= '{default: '0};
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
            move_made_q  <= 1'b0;
            reset_req_q  <= 1'b0;
            last_cmd_q   <= '0;
            cmd_count_q  <= '0;
            err_count_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
            move_made_q  <= move_made_d;
            reset_req_q  <= reset_req_d;
            last_cmd_q   <= last_cmd_d;
            cmd_count_q  <= cmd_count_d;
            err_count_q  <= err_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign bus.move_left  = move_left_q;
    assign bus.move_right = move_right_q;
    assign bus.move_made  = move_made_q;
    assign bus.reset_req  = reset_req_q;
    assign bus.last_cmd   = last_cmd_q;
    assign bus.cmd_count  = cmd_count_q;
    assign bus.err_count  = err_count_q;
    assign bus.overflow   = overflow_q;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: expected pulses queued at stimulus time,
// popped and compared by a monitor when the DUT emits them.
module tb_uart_cmd_decoder;
    localparam int GAP = 16;
    localparam int DEPTH = 4;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_vec;
    int   n_err;
    int   pulse_cnt;
    int   pulse_cyc [$];
    int   sb [$];
    int   peak;
    logic prev_hot;

    uart_cmd_decoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_cmd_decoder #(
        .GAP_CYCLES(GAP),
        .FIFO_DEPTH(DEPTH),
        .CMD_RIGHT (8'h01),
        .CMD_LEFT  (8'h02),
        .CMD_DROP  (8'h03),
        .CMD_RESET (8'h04)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // 1 = right, 2 = left, 3 = drop, 7 = more than one pulse high at once
    always @(negedge clk) begin
        int nhot;
        int kind;
        nhot = int'(bus.move_right) + int'(bus.move_left) + int'(bus.move_made);
        if (nhot != 0) begin
            kind = bus.move_made ? 3 : (bus.move_left ? 2 : 1);
            if (nhot > 1) kind = 7;
            pulse_cyc.push_back(cyc);
            pulse_cnt++;
            if (sb.size() == 0) check("unexpected_pulse", 32'(kind), 32'd0);
            else check("pulse_kind", 32'(kind), 32'(sb.pop_front()));
            check("pulse_width", 32'(prev_hot), 32'd0);
        end
        prev_hot = (nhot != 0);
        if (int'(bus.fifo_level) > peak) peak = int'(bus.fifo_level);
    end

    task automatic send_byte(input logic [7:0] b, output int rx_edge);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rx_edge = cyc;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.clr_stats = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget, input string tag);
        int k;
        k = 0;
        while (pulse_cnt < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(pulse_cnt >= target), 32'd1);
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.move_left, bus.move_right, bus.move_made, bus.reset_req, bus.overflow,
                    bus.last_cmd, bus.cmd_count, bus.err_count, bus.fifo_level});
    endfunction

    initial begin
        int e;
        int n0;
        int base;
        n_vec = 0; n_err = 0; pulse_cnt = 0; peak = 0; prev_hot = 1'b0; cyc = 0;
        rstn = 1'b0;
        bus.rx_data = '0; bus.rx_valid = 1'b0; bus.accept_en = 1'b0; bus.clr_stats = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("post_reset_outputs", all_outs(), 32'd0);

        // Single move: level 1 after the write edge, pulse one edge later
        bus.accept_en = 1'b1;
        sb.push_back(1);
        send_byte(8'h01, e);
        check("single_level", 32'(bus.fifo_level), 32'd1);
        wait_pulses(1, 10, "single_timeout");
        check("single_latency", 32'(pulse_cyc[0]), 32'(e + 1));
        check("single_cmd_count", 32'(bus.cmd_count), 32'd1);
        check("single_last_cmd", 32'(bus.last_cmd), 32'h01);
        repeat (GAP + 4) @(negedge clk);

        // Burst of three back-to-back bytes
        peak = 0;
        base = pulse_cnt;
        sb.push_back(1); sb.push_back(2); sb.push_back(3);
        @(negedge clk);
        bus.rx_data = 8'h01; bus.rx_valid = 1'b1;
        @(negedge clk);
        n0 = cyc;
        bus.rx_data = 8'h02;
        @(negedge clk);
        bus.rx_data = 8'h03;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        wait_pulses(base + 3, 100, "burst_timeout");
        check("burst_first", 32'(pulse_cyc[base]), 32'(n0 + 1));
        check("burst_space1", 32'(pulse_cyc[base + 1] - pulse_cyc[base]), 32'(GAP + 2));
        check("burst_space2", 32'(pulse_cyc[base + 2] - pulse_cyc[base + 1]), 32'(GAP + 2));
        check("burst_peak", 32'(peak), 32'd2);
        check("burst_cmd_count", 32'(bus.cmd_count), 32'd4);
        repeat (GAP + 4) @(negedge clk);

        // Hold-off with overflow on the fifth move
        pulse_clr();
        bus.accept_en = 1'b0;
        base = pulse_cnt;
        sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(1);
        send_byte(8'h01, e); send_byte(8'h02, e); send_byte(8'h03, e);
        send_byte(8'h01, e); send_byte(8'h02, e);
        repeat (5) @(negedge clk);
        check("hold_no_pulse", 32'(pulse_cnt), 32'(base));
        check("hold_level", 32'(bus.fifo_level), 32'd4);
        check("hold_overflow", 32'(bus.overflow), 32'd1);
        check("hold_err", 32'(bus.err_count), 32'd1);
        check("hold_cmd_count", 32'(bus.cmd_count), 32'd4);
        check("hold_last_cmd", 32'(bus.last_cmd), 32'h01);
        bus.accept_en = 1'b1;
        wait_pulses(base + 4, 120, "hold_release_timeout");
        check("hold_drained", 32'(bus.fifo_level), 32'd0);
        repeat (GAP + 4) @(negedge clk);

        // Invalid bytes saturate err_count
        base = pulse_cnt;
        for (int i = 0; i < 20; i++) send_byte(8'hFF, e);
        check("inv_err_sat", 32'(bus.err_count), 32'd15);
        check("inv_cmd_count", 32'(bus.cmd_count), 32'd4);
        check("inv_no_pulse", 32'(pulse_cnt), 32'(base));
        pulse_clr();
        check("clr_stats", 32'({bus.overflow, bus.cmd_count, bus.err_count}), 32'd0);
        @(negedge clk);
        bus.rx_data = 8'hFF; bus.rx_valid = 1'b1; bus.clr_stats = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0; bus.clr_stats = 1'b0;
        check("clr_priority", 32'(bus.err_count), 32'd0);

        // Reset command flushes the queue
        bus.accept_en = 1'b0;
        base = pulse_cnt;
        send_byte(8'h01, e); send_byte(8'h02, e); send_byte(8'h03, e);
        check("rcmd_level_before", 32'(bus.fifo_level), 32'd3);
        send_byte(8'h04, e);
        check("rcmd_req", 32'(bus.reset_req), 32'd1);
        check("rcmd_level", 32'(bus.fifo_level), 32'd0);
        check("rcmd_cmd_count", 32'(bus.cmd_count), 32'd4);
        check("rcmd_last_cmd", 32'(bus.last_cmd), 32'h04);
        @(negedge clk);
        check("rcmd_req_one_cycle", 32'(bus.reset_req), 32'd0);
        bus.accept_en = 1'b1;
        repeat (30) @(negedge clk);
        check("rcmd_no_pulse", 32'(pulse_cnt), 32'(base));

        // Asynchronous reset while in GAP
        base = pulse_cnt;
        sb.push_back(1);
        send_byte(8'h01, e);
        wait_pulses(base + 1, 10, "async_pre_timeout");
        repeat (5) @(negedge clk);
        check("async_pre_count", 32'(bus.cmd_count), 32'd5);
        #2 rstn = 1'b0;
        #1 check("async_outputs_zero", all_outs(), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        base = pulse_cnt;
        sb.push_back(2);
        send_byte(8'h02, e);
        wait_pulses(base + 1, 10, "async_post_timeout");
        check("async_post_latency", 32'(pulse_cyc[base]), 32'(e + 1));

        repeat (GAP + 4) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/uart_cmd_decoder.md
# uart_cmd_decoder

Converts bytes from the UART receiver into the one-cycle control pulses the Connect-4 game top consumes: `move_left`, `move_right`, `move_made`, plus a reset request. It sits between `UART_RX` and the game FSM inputs, running in the `VGA_CLK` domain. Commands are buffered in a small FIFO and released one at a time, only while the game accepts input, with a guaranteed idle gap between pulses. Statistics are exported for the seven-segment displays.

## Interface
Parameters:
- `GAP_CYCLES`, default 16: idle cycles forced after every emitted move pulse; legal range 1..255.
- `FIFO_DEPTH`, default 4: command FIFO entries; power of 2, 2..8.
- `CMD_RIGHT`, default 8'h01: byte for move right.
- `CMD_LEFT`, default 8'h02: byte for move left.
- `CMD_DROP`, default 8'h03: byte for drop piece.
- `CMD_RESET`, default 8'h04: byte for game reset request.

Ports:
- `clk`, input, 1: the only clock; all logic is rising-edge.
- `rstn`, input, 1: asynchronous, active-low reset.
- `rx_data`, input, 8: received byte; valid only while `rx_valid` is high.
- `rx_valid`, input, 1: one-cycle strobe per received byte.
- `accept_en`, input, 1: high when the game FSM accepts moves. Driven by the top as state == 3'b001.
- `clr_stats`, input, 1: synchronous clear of `cmd_count`, `err_count` and `overflow`.
- `move_left`, `move_right`, `move_made`, output, 1 each: one-cycle pulses.
- `reset_req`, output, 1: one-cycle pulse requesting a game reset.
- `last_cmd`, output, 8: last byte that matched a valid command.
- `cmd_count`, output, 8: count of accepted commands; wraps modulo 256.
- `err_count`, output, 4: count of invalid bytes plus dropped bytes; saturates at 15.
- `overflow`, output, 1: sticky flag; set when a command is dropped because the FIFO is full.
- `fifo_level`, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **Classification.** Applied on every `rx_valid` cycle.
  - `rx_data` equal to `CMD_LEFT`, `CMD_RIGHT` or `CMD_DROP`: push a 2-bit opcode into the FIFO, increment `cmd_count`, load `last_cmd`.
  - `rx_data` equal to `CMD_RESET`: bypasses the FIFO (see reset command below). Increments `cmd_count` and loads `last_cmd`.
  - Any other byte: increment `err_count` (saturating). No other effect.
- **FIFO full.** A move command arriving when the FIFO is full is dropped:
  - `overflow` is set and `err_count` increments.
  - `cmd_count` and `last_cmd` are unchanged.
  - Exception: if a pop occurs in the same cycle, the push succeeds.
- **Emission FSM.** States IDLE, PULSE, GAP.
  - IDLE: if the FIFO is non-empty and `accept_en`=1, pop the head and go to PULSE. Otherwise stay in IDLE.
  - PULSE: exactly one of `move_left`, `move_right`, `move_made` is high for this one cycle, selected by the popped opcode. Load the gap counter with `GAP_CYCLES`, then go to GAP.
  - GAP: decrement the counter each cycle. At zero, go to IDLE. `accept_en` is ignored in this state.
- **Reset command.**
  - `reset_req` pulses in the cycle after `rx_valid`.
  - The FIFO is flushed in that same edge.
  - A pop that would have happened in the same cycle is suppressed.
  - If the FSM is in PULSE, that pulse completes normally; the FSM then proceeds through GAP as usual.
- **`clr_stats`.** Takes priority over any same-cycle increment. Does not touch the FIFO or the FSM.
- **`accept_en` low.** Commands accumulate in the FIFO and are not discarded.

## Timing
- All outputs are registered. While `rstn`=0, every output is 0, the FIFO is empty and the FSM is in IDLE.
- Release of `rstn` takes effect synchronously to `clk`.
- Latency, FIFO empty and FSM in IDLE with `accept_en`=1:
  - `rx_valid` at edge N writes the entry; `fifo_level` reads 1 after edge N.
  - Pop occurs at edge N+1.
  - The move pulse is high for the cycle following edge N+1.
- Minimum spacing between move pulses is `GAP_CYCLES`+2 cycles, measured rising edge to rising edge.
- `fifo_level` and the counters update in the cycle after the triggering edge.
- Counter widths:
  - `cmd_count` wraps from 255 to 0.
  - `err_count` holds at 15.
- `rx_valid` may be high on consecutive cycles; each cycle is treated as a separate byte.

## Test plan
- **Single move:** reset, `accept_en`=1, send 8'h01 → `move_right` is high for exactly 1 cycle, 2 cycles after `rx_valid`; `cmd_count`=1, `last_cmd`=8'h01.
- **Burst and spacing:** send 01, 02, 03 back-to-back with `GAP_CYCLES`=16 → pulses appear in order right, left, drop, spaced exactly 18 cycles apart; `fifo_level` peaks at 2.
- **Hold-off:** with `accept_en`=0, send 5 moves with `FIFO_DEPTH`=4 → no pulses; `fifo_level`=4, `overflow`=1, `err_count`=1, `cmd_count`=4. Then raise `accept_en` → 4 pulses are emitted.
- **Invalid bytes:** send 20 bytes of 8'hFF → `err_count` saturates at 15, no pulses. Then assert `clr_stats` → all statistics read 0.
- **Reset command:** queue 3 moves with `accept_en`=0, then send 8'h04 → `reset_req` pulses 1 cycle later, `fifo_level`=0, and no move pulses follow after `accept_en` rises.
- **Asynchronous reset mid-GAP:** pull `rstn` low during GAP → all outputs 0 immediately, no clock edge required. After release, a new command is emitted with the normal 2-cycle latency.
